// File: rtl/tt_capture_sweep_if.sv
// Result channel of the truth-table sweeper: packed table,
// its weight, and a valid/ready handshake.
interface tt_capture_sweep_if;
  logic [127:0] tt;
  logic [7:0]   weight;
  logic         tt_valid;
  logic         tt_ready;

  modport master (
    output tt,
    output weight,
    output tt_valid,
    input  tt_ready
  );

  modport slave (
    input  tt,
    input  weight,
    input  tt_valid,
    output tt_ready
  );
endinterface

// File: rtl/tt_capture_sweep.sv
// Sweeps all 128 vectors of a 7-input function and packs the
// sampled outputs into a truth table plus its popcount.
module tt_capture_sweep #(
  parameter int LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic [6:0] x_vec,
  output logic       x_vld,
  input  logic       f_in,
  tt_capture_sweep_if.master res
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] DRAIN_LAST =
    (LAT == 0) ? 3'd0 : 3'(LAT - 1);

  logic [1:0]   state;
  logic [2:0]   drain_cnt;
  logic [127:0] tt_q;
  logic [7:0]   wt_q;
  logic         smp_vld;
  logic [6:0]   smp_idx;

  // Index/valid travel alongside the DUT pipe so each
  // f_in lands in the bit of the vector that produced it.
  generate
    if (LAT == 0) begin : g_direct
      assign smp_vld = x_vld;
      assign smp_idx = x_vec;
    end else begin : g_delay
      logic [LAT-1:0] vld_pipe;
      logic [6:0]     idx_pipe [LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
          for (int i = 0; i < LAT; i++) begin
            idx_pipe[i] <= '0;
          end
        end else begin
          vld_pipe[0] <= x_vld;
          idx_pipe[0] <= x_vec;
          for (int i = 1; i < LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
          end
        end
      end

      assign smp_vld = vld_pipe[LAT-1];
      assign smp_idx = idx_pipe[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      x_vec     <= '0;
      x_vld     <= 1'b0;
      tt_q      <= '0;
      wt_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SWEEP;
            x_vec <= '0;
            x_vld <= 1'b1;
            tt_q  <= '0;
            wt_q  <= '0;
          end
        end
        SWEEP: begin
          if (x_vec == 7'd127) begin
            x_vld     <= 1'b0;
            drain_cnt <= '0;
            state     <= (LAT == 0) ? DONE : DRAIN;
          end else begin
            x_vec <= x_vec + 7'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        DONE: begin
          if (res.tt_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (smp_vld) begin
        tt_q[smp_idx] <= f_in;
        wt_q          <= wt_q + {7'd0, f_in};
      end
    end
  end

  assign busy         = (state == SWEEP) || (state == DRAIN);
  assign res.tt_valid = (state == DONE);
  assign res.tt       = tt_q;
  assign res.weight   = wt_q;

endmodule

// File: tb/tb_tt_capture_sweep.sv
// Directed bench: four sweepers (LAT 0,1,3,7) each fed by a
// selectable 7-input function through a matching register pipe.
module tb_tt_capture_sweep;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fsel = 3'd0;
  logic       start_s [4];
  logic       ready_s [4];

  logic         busy_a [4];
  logic [6:0]   xv_a   [4];
  logic         xvld_a [4];
  logic [127:0] tt_a   [4];
  logic [7:0]   wt_a   [4];
  logic         ttv_a  [4];

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;

  int unsigned sa [5];
  int unsigned sb [5];
  int unsigned sc [5];
  logic [2:0]  inv [5];

  always #5 clk = ~clk;

  function automatic logic maj(input logic a, input logic b,
                               input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic net_eval(input logic [6:0] x);
    logic [11:0] n;
    n = '0;
    n[6:0] = x;
    for (int g = 0; g < 5; g++) begin
      n[7+g] = maj(n[sa[g]] ^ inv[g][0],
                   n[sb[g]] ^ inv[g][1],
                   n[sc[g]] ^ inv[g][2]);
    end
    return n[11];
  endfunction

  function automatic logic fn(input logic [2:0] s,
                              input logic [6:0] x);
    case (s)
      3'd0:    return maj(x[0], x[1], x[2]);
      3'd1:    return 1'b0;
      3'd2:    return 1'b1;
      3'd3:    return x[6];
      default: return net_eval(x);
    endcase
  endfunction

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_inst
      localparam int L = (k == 0) ? 0 : (k == 1) ? 1 :
                         (k == 2) ? 3 : 7;
      tt_capture_sweep_if rif ();
      logic fc;
      logic fi;

      assign fc = fn(fsel, xv_a[k]);

      if (L == 0) begin : g_comb
        assign fi = fc;
      end else begin : g_pipe
        logic [7:0] pipe;
        always @(posedge clk) pipe <= {pipe[6:0], fc};
        assign fi = pipe[L-1];
      end

      assign rif.tt_ready = ready_s[k];

      tt_capture_sweep #(.LAT(L)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start_s[k]),
        .busy  (busy_a[k]),
        .x_vec (xv_a[k]),
        .x_vld (xvld_a[k]),
        .f_in  (fi),
        .res   (rif)
      );

      assign tt_a[k]  = rif.tt;
      assign wt_a[k]  = rif.weight;
      assign ttv_a[k] = rif.tt_valid;
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n);
    tick();
    start_s[n] = 1'b1;
    tick();
    start_s[n] = 1'b0;
  endtask

  task automatic run_net(input int n, input int lat,
                         input logic [127:0] exp_tt,
                         input logic [7:0] exp_w);
    do_start(n);
    repeat (127 + lat) tick();
    check("net_early", 128'(ttv_a[n]), 128'd0);
    tick();
    check("net_valid", 128'(ttv_a[n]), 128'd1);
    check("net_tt", tt_a[n], exp_tt);
    check("net_w", 128'(wt_a[n]), 128'(exp_w));
  endtask

  localparam logic [127:0] TT_MAJ = {16{8'hE8}};
  localparam logic [127:0] TT_X6  = {{64{1'b1}}, {64{1'b0}}};

  initial begin
    logic [127:0] exp_tt;
    logic [7:0]   exp_w;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b1;
    end
    repeat (3) tick();
    check("rst_busy", 128'(busy_a[0]), 128'd0);
    check("rst_xvec", 128'(xv_a[0]), 128'd0);
    check("rst_xvld", 128'(xvld_a[0]), 128'd0);
    check("rst_tt", tt_a[0], 128'd0);
    check("rst_w", 128'(wt_a[0]), 128'd0);
    check("rst_ttv", 128'(ttv_a[0]), 128'd0);
    rst = 1'b0;

    // maj(x0,x1,x2) with LAT 0
    fsel = 3'd0;
    do_start(0);
    check("maj_x0", 128'(xv_a[0]), 128'd0);
    check("maj_vld", 128'(xvld_a[0]), 128'd1);
    check("maj_busy", 128'(busy_a[0]), 128'd1);
    repeat (4) tick();
    check("maj_x4", 128'(xv_a[0]), 128'd4);
    repeat (123) tick();
    check("maj_x127", 128'(xv_a[0]), 128'd127);
    check("maj_early", 128'(ttv_a[0]), 128'd0);
    tick();
    check("maj_valid", 128'(ttv_a[0]), 128'd1);
    check("maj_tt", tt_a[0], TT_MAJ);
    check("maj_w", 128'(wt_a[0]), 128'd64);
    check("maj_idle", 128'(busy_a[0]), 128'd0);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    check("done_start_ign", 128'(busy_a[0]), 128'd0);
    check("maj_drop", 128'(ttv_a[0]), 128'd0);

    // back-to-back f=0 then f=1
    fsel = 3'd1;
    do_start(0);
    repeat (128) tick();
    check("z_valid", 128'(ttv_a[0]), 128'd1);
    check("z_tt", tt_a[0], 128'd0);
    check("z_w", 128'(wt_a[0]), 128'd0);
    fsel = 3'd2;
    do_start(0);
    check("o_busy", 128'(busy_a[0]), 128'd1);
    repeat (128) tick();
    check("o_valid", 128'(ttv_a[0]), 128'd1);
    check("o_tt", tt_a[0], {128{1'b1}});
    check("o_w", 128'(wt_a[0]), 128'd128);

    // f = x6 through LAT 3
    fsel = 3'd3;
    do_start(2);
    repeat (127) tick();
    check("x6_vld127", 128'(xvld_a[2]), 128'd1);
    for (int d = 0; d < 3; d++) begin
      tick();
      check("x6_drain_vld", 128'(xvld_a[2]), 128'd0);
      check("x6_drain_busy", 128'(busy_a[2]), 128'd1);
      check("x6_drain_x", 128'(xv_a[2]), 128'd127);
      check("x6_drain_ttv", 128'(ttv_a[2]), 128'd0);
    end
    tick();
    check("x6_valid", 128'(ttv_a[2]), 128'd1);
    check("x6_tt", tt_a[2], TT_X6);
    check("x6_w", 128'(wt_a[2]), 128'd64);
    check("x6_busy", 128'(busy_a[2]), 128'd0);

    // back-pressure on LAT 0
    fsel = 3'd0;
    ready_s[0] = 1'b0;
    do_start(0);
    repeat (128) tick();
    for (int c = 0; c < 50; c++) begin
      if (c == 10 || c == 30) start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      check("bp_valid", 128'(ttv_a[0]), 128'd1);
      check("bp_tt", tt_a[0], TT_MAJ);
      check("bp_w", 128'(wt_a[0]), 128'd64);
      check("bp_busy", 128'(busy_a[0]), 128'd0);
    end
    ready_s[0] = 1'b1;
    tick();
    check("bp_release", 128'(ttv_a[0]), 128'd0);
    check("bp_rel_busy", 128'(busy_a[0]), 128'd0);

    // reset in the middle of a sweep
    fsel = 3'd2;
    do_start(0);
    repeat (60) tick();
    check("mid_x", 128'(xv_a[0]), 128'd60);
    check("mid_w", 128'(wt_a[0]), 128'd60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ab_busy", 128'(busy_a[0]), 128'd0);
    check("ab_tt", tt_a[0], 128'd0);
    check("ab_w", 128'(wt_a[0]), 128'd0);
    check("ab_xvld", 128'(xvld_a[0]), 128'd0);
    check("ab_xvec", 128'(xv_a[0]), 128'd0);
    fsel = 3'd0;
    do_start(0);
    repeat (128) tick();
    check("re_valid", 128'(ttv_a[0]), 128'd1);
    check("re_tt", tt_a[0], TT_MAJ);
    check("re_w", 128'(wt_a[0]), 128'd64);

    // random majority network at LAT 0, 1, 7
    for (int g = 0; g < 5; g++) begin
      sa[g]  = $urandom_range(0, 6 + g);
      sb[g]  = $urandom_range(0, 6 + g);
      sc[g]  = $urandom_range(0, 6 + g);
      inv[g] = 3'($urandom_range(0, 7));
    end
    exp_tt = '0;
    exp_w = '0;
    for (int i = 0; i < 128; i++) begin
      exp_tt[i] = net_eval(7'(i));
      exp_w = exp_w + {7'd0, exp_tt[i]};
    end
    fsel = 3'd4;
    run_net(0, 0, exp_tt, exp_w);
    run_net(1, 1, exp_tt, exp_w);
    run_net(3, 7, exp_tt, exp_w);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/tt_capture_sweep.md
Name: tt_capture_sweep

Overview:
- Exhaustive truth-table extractor for one 7-input single-output function under classification (a majority-gate network or any combinational block with inputs x0..x6 and one output).
- Drives all 128 input vectors in ascending order and samples the function output, optionally through a pipelined path.
- Packs the result into a 128-bit truth table plus its weight (count of ones), handed downstream over a valid/ready handshake.
- Truth-table bit i = f(x = i), where x0 is the LSB of i; printed MSB-first as 32 hex digits, this is the team's canonical function identifier.

Parameters:
- LAT, 0, register stages between x_vec leaving this block and f_in arriving (0 = purely combinational DUT); legal range 0..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  out  1  high in SWEEP and DRAIN.
- x_vec  out  7  input vector to DUT; bit k drives xk.
- x_vld  out  1  high while x_vec carries a live sweep vector.
- f_in  in  1  DUT output, LAT cycles after matching x_vec.
- tt  out  128  captured truth table.
- weight  out  8  popcount of tt, 0..128.
- tt_valid  out  1  result available.
- tt_ready  in  1  downstream accepts result.

Behaviour:
- Reset, synchronous and applied to every register (including any pending result): state=IDLE; x_vec=0, x_vld=0, busy=0, tt=0, weight=0, tt_valid=0.
- State machine:
  - IDLE: start=1 -> SWEEP; clear capture register and weight accumulator.
  - SWEEP: x_vld=1; x_vec steps 0,1,...,127, one value per cycle, first cycle after start. After x_vec=127 -> DRAIN if LAT>0, else DONE.
  - DRAIN: x_vld=0, x_vec held at 127; lasts exactly LAT cycles -> DONE.
  - DONE: tt_valid=1; tt and weight stable. tt_valid&tt_ready -> IDLE; tt_valid drops the next cycle.
- Capture:
  - A 7-bit index, delayed LAT cycles alongside x_vld, selects the bit written.
  - f_in is sampled when the delayed valid is 1; tt[idx] <= f_in; weight += f_in.
  - No sample is taken when the delayed valid is 0.
- Widths: weight is 8 bits and must reach 128 without wrap; the x_vec counter wraps internally 127->0 but is not used past 127.
- Timing:
  - start accepted at cycle t -> x_vec=i at cycle t+1+i.
  - tt_valid first high at cycle t+129+LAT.
  - Minimum start-to-start period is 130+LAT cycles with tt_ready tied high.
- start while busy or in DONE: ignored, no queuing.
- Back-pressure: DONE holds indefinitely while tt_ready=0; tt and weight must not change.
- start and tt_ready in the same DONE cycle: handshake completes -> IDLE; that start is ignored.
- rst mid-sweep: abort, all outputs to reset values next cycle; in-flight samples discarded.
- f_in is X-tolerant outside sample cycles; it is never captured then.

Test Plan:
- LAT=0, f = maj(x0,x1,x2); start -> tt = 0xE8 repeated 16 times (E8E8...E8), weight=64, tt_valid exactly 129 cycles after start.
- LAT=0, f=0 then f=1 on back-to-back sweeps with tt_ready=1 -> tt=0/weight=0, then tt=all-ones/weight=128 (no 8-bit overflow); second start issued in the cycle after handshake is accepted.
- LAT=3, f = x6 via 3-stage pipe -> tt = 0xFFFFFFFFFFFFFFFF0000000000000000, weight=64, tt_valid at t+132; x_vld low for the 3 DRAIN cycles.
- Back-pressure: hold tt_ready=0 for 50 cycles in DONE -> tt_valid stays 1, tt and weight unchanged; extra start pulses ignored; release -> IDLE next cycle.
- rst asserted at sweep cycle 60 -> next cycle busy=0, tt=0, weight=0, x_vld=0; a fresh start yields a correct full table.
- Random 7-input majority-network DUT, LAT in {0,1,7} -> tt matches reference-model evaluation over all 128 vectors; weight equals popcount(tt).
